// File: rtl/deal_arbiter.sv
// Card-deck arbiter for the blackjack datapath: round-robin grants between player and
// dealer, deck handshake with response timeout, and per-hand soft-ace scoring.
module deal_arbiter #(
  parameter int         TIMEOUT  = 16,
  parameter logic [3:0] ACE_CODE = 4'd11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_round,
  input  logic       req_p,
  input  logic       req_d,
  output logic       ack_p,
  output logic       ack_d,
  output logic       err,
  output logic       deck_get_card,
  input  logic       deck_card_rdy,
  input  logic [3:0] deck_card,
  output logic [3:0] last_card,
  output logic [4:0] score_p,
  output logic [4:0] score_d,
  output logic       soft_p,
  output logic       soft_d,
  output logic       bust_p,
  output logic       bust_d,
  output logic [3:0] ncards_p,
  output logic [3:0] ncards_d,
  output logic       busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, ACK, REJ} state_t;

  state_t           state, state_nxt;
  logic             gnt, gnt_nxt;   // 0 = player, 1 = dealer
  logic             ptr, ptr_nxt;   // 0 = player preferred on a tie
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic             err_r, err_nxt;
  logic [3:0]       card_r;

  logic [4:0] hard_p, hard_d;
  logic       ace_p, ace_d;

  logic       pick;
  logic       pick_full;
  logic [4:0] cur_hard;
  logic       cur_ace;
  logic [3:0] cur_n;
  logic       card_ok;
  logic       is_ace;
  logic [4:0] add_val;
  logic [4:0] new_hard;
  logic       new_ace;
  logic [5:0] new_ss;
  logic       upd;

  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[5] ? 5'd31 : s[4:0];
  endfunction

  // Returns {soft, score}: an ace counts as 11 only if that keeps the hand at 21 or less.
  function automatic logic [5:0] score_of(input logic [4:0] hard, input logic ace);
    if (ace && (hard <= 5'd11)) return {1'b1, hard + 5'd10};
    else                        return {1'b0, hard};
  endfunction

  // Grant selection and the hand-update values for the currently granted side
  always_comb begin
    pick      = (req_p && req_d) ? ptr : req_d;
    pick_full = pick ? (bust_d || (ncards_d == 4'd15)) : (bust_p || (ncards_p == 4'd15));
    cur_hard  = gnt ? hard_d : hard_p;
    cur_ace   = gnt ? ace_d : ace_p;
    cur_n     = gnt ? ncards_d : ncards_p;
    card_ok   = (card_r >= 4'd2) && (card_r <= 4'd11);
    is_ace    = (card_r == ACE_CODE);
    add_val   = is_ace ? 5'd1 : {1'b0, card_r};
    new_hard  = sat_add(cur_hard, add_val);
    new_ace   = cur_ace | is_ace;
    new_ss    = score_of(new_hard, new_ace);
    upd       = (state == ACCUM) && card_ok;
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    tcnt_nxt  = tcnt;
    err_nxt   = err_r;
    if (new_round) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_p || req_d) begin
            gnt_nxt   = pick;
            ptr_nxt   = ~pick;
            state_nxt = pick_full ? REJ : ISSUE;
          end
        end
        ISSUE: begin
          tcnt_nxt  = '0;
          state_nxt = WAIT;
        end
        WAIT: begin
          if (deck_card_rdy) begin
            state_nxt = ACCUM;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
            if (tcnt == CNT_LAST) begin
              err_nxt   = 1'b1;
              state_nxt = ACK;
            end
          end
        end
        ACCUM: begin
          err_nxt   = ~card_ok;
          state_nxt = ACK;
        end
        ACK:     state_nxt = IDLE;
        REJ:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      ptr   <= 1'b0;
      tcnt  <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      tcnt  <= tcnt_nxt;
      err_r <= err_nxt;
    end
  end

  // Deck data capture; only meaningful once the handshake completes, so no reset needed
  always_ff @(posedge clk) begin
    if ((state == WAIT) && deck_card_rdy) card_r <= deck_card;
  end

  // Hand state: hard sum, ace flag and the registered score/soft/bust derived from them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hard_p    <= '0;
      hard_d    <= '0;
      ace_p     <= 1'b0;
      ace_d     <= 1'b0;
      score_p   <= '0;
      score_d   <= '0;
      soft_p    <= 1'b0;
      soft_d    <= 1'b0;
      bust_p    <= 1'b0;
      bust_d    <= 1'b0;
      ncards_p  <= '0;
      ncards_d  <= '0;
      last_card <= '0;
    end else if (new_round) begin
      hard_p    <= '0;
      hard_d    <= '0;
      ace_p     <= 1'b0;
      ace_d     <= 1'b0;
      score_p   <= '0;
      score_d   <= '0;
      soft_p    <= 1'b0;
      soft_d    <= 1'b0;
      bust_p    <= 1'b0;
      bust_d    <= 1'b0;
      ncards_p  <= '0;
      ncards_d  <= '0;
      last_card <= '0;
    end else if (upd) begin
      last_card <= card_r;
      if (gnt) begin
        hard_d   <= new_hard;
        ace_d    <= new_ace;
        score_d  <= new_ss[4:0];
        soft_d   <= new_ss[5];
        bust_d   <= (new_hard > 5'd21);
        ncards_d <= cur_n + 4'd1;
      end else begin
        hard_p   <= new_hard;
        ace_p    <= new_ace;
        score_p  <= new_ss[4:0];
        soft_p   <= new_ss[5];
        bust_p   <= (new_hard > 5'd21);
        ncards_p <= cur_n + 4'd1;
      end
    end
  end

  always_comb begin
    ack_p         = ((state == ACK) || (state == REJ)) && !gnt;
    ack_d         = ((state == ACK) || (state == REJ)) && gnt;
    err           = (state == REJ) || ((state == ACK) && err_r);
    deck_get_card = (state == ISSUE);
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_deal_arbiter.sv
// Directed bench for deal_arbiter: hand-computed scores, latencies and arbitration order.
module tb_deal_arbiter;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset, new_round, req_p, req_d, deck_card_rdy;
  logic [3:0] deck_card;
  logic       ack_p, ack_d, err, deck_get_card, soft_p, soft_d, bust_p, bust_d, busy;
  logic [3:0] last_card, ncards_p, ncards_d;
  logic [4:0] score_p, score_d;

  int checks = 0;
  int errors = 0;

  deal_arbiter #(.TIMEOUT(TO), .ACE_CODE(4'd11)) dut (
    .clk(clk), .reset(reset), .new_round(new_round), .req_p(req_p), .req_d(req_d),
    .ack_p(ack_p), .ack_d(ack_d), .err(err), .deck_get_card(deck_get_card),
    .deck_card_rdy(deck_card_rdy), .deck_card(deck_card), .last_card(last_card),
    .score_p(score_p), .score_d(score_d), .soft_p(soft_p), .soft_d(soft_d),
    .bust_p(bust_p), .bust_d(bust_d), .ncards_p(ncards_p), .ncards_d(ncards_d), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b1; new_round = 1'b0; req_p = 1'b0; req_d = 1'b0;
    deck_card_rdy = 1'b0; deck_card = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raises one request, waits (bounded) for its ack; lat = -1 if no ack arrived.
  task automatic do_req(input bit side, input logic [3:0] card, input bit rdy,
                        output int lat, output bit e, output int gets);
    lat = -1; e = 1'b0; gets = 0;
    @(negedge clk);
    deck_card = card; deck_card_rdy = rdy;
    if (side) req_d = 1'b1; else req_p = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (deck_get_card) gets++;
      if (side ? ack_d : ack_p) begin
        lat = i; e = err;
        break;
      end
    end
    req_p = 1'b0; req_d = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ack_p, ack_d, err, deck_get_card, last_card, score_p, score_d, soft_p, soft_d,
         bust_p, bust_d, ncards_p, ncards_d, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
  endtask

  task automatic test_player_deal();
    int lat, gets; bit e;
    apply_reset();
    do_req(1'b0, 4'd10, 1'b1, lat, e, gets);
    checks++; if (lat !== 4) begin errors++; $display("FAIL p_latency: got %0d required 4", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL p_err1: got %0b required 0", e); end
    checks++; if (gets !== 1) begin errors++; $display("FAIL p_getcard: got %0d required 1", gets); end
    do_req(1'b0, 4'd7, 1'b1, lat, e, gets);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL p_err2: got %0b required 0", e); end
    checks++; if (score_p !== 5'd17) begin errors++; $display("FAIL p_score: got %0d required 17", score_p); end
    checks++; if (soft_p !== 1'b0) begin errors++; $display("FAIL p_soft: got %0b required 0", soft_p); end
    checks++; if (ncards_p !== 4'd2) begin errors++; $display("FAIL p_ncards: got %0d required 2", ncards_p); end
    checks++; if (last_card !== 4'd7) begin errors++; $display("FAIL p_last: got %0d required 7", last_card); end
    checks++; if (ncards_d !== 4'd0) begin errors++; $display("FAIL p_dealer_untouched: got %0d required 0", ncards_d); end
  endtask

  task automatic test_soft_aces();
    int lat, gets; bit e;
    logic [3:0] cards [4] = '{4'd11, 4'd11, 4'd9, 4'd5};
    logic [4:0] exp_sc [4] = '{5'd11, 5'd12, 5'd21, 5'd16};
    logic       exp_sf [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      do_req(1'b1, cards[k], 1'b1, lat, e, gets);
      checks++;
      if (score_d !== exp_sc[k]) begin
        errors++; $display("FAIL d_score_%0d: got %0d required %0d", k, score_d, exp_sc[k]);
      end
      checks++;
      if (soft_d !== exp_sf[k]) begin
        errors++; $display("FAIL d_soft_%0d: got %0b required %0b", k, soft_d, exp_sf[k]);
      end
    end
    checks++; if (ncards_d !== 4'd4) begin errors++; $display("FAIL d_ncards: got %0d required 4", ncards_d); end
    checks++; if (bust_d !== 1'b0) begin errors++; $display("FAIL d_bust: got %0b required 0", bust_d); end
  endtask

  task automatic test_round_robin();
    int order [4] = '{3, 3, 3, 3};
    int n = 0;
    int first = -1;
    apply_reset();
    @(negedge clk);
    deck_card = 4'd2; deck_card_rdy = 1'b1; req_p = 1'b1; req_d = 1'b1;
    for (int i = 1; i <= 40 && n < 4; i++) begin
      @(negedge clk);
      if (ack_p || ack_d) begin
        if (n == 0) first = i;
        order[n] = ack_d ? 1 : 0;
        n++;
      end
    end
    req_p = 1'b0; req_d = 1'b0;
    checks++; if (first !== 4) begin errors++; $display("FAIL rr_first_latency: got %0d required 4", first); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (order[k] !== (k % 2)) begin
        errors++; $display("FAIL rr_order_%0d: got side %0d required %0d", k, order[k], k % 2);
      end
    end
    checks++; if (score_p !== 5'd4) begin errors++; $display("FAIL rr_score_p: got %0d required 4", score_p); end
    checks++; if (score_d !== 5'd4) begin errors++; $display("FAIL rr_score_d: got %0d required 4", score_d); end
  endtask

  task automatic test_errors();
    int lat, gets; bit e;
    apply_reset();
    do_req(1'b0, 4'd5, 1'b0, lat, e, gets);
    checks++; if (lat !== 2 + TO) begin errors++; $display("FAIL to_latency: got %0d required %0d", lat, 2 + TO); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL to_err: got %0b required 1", e); end
    checks++; if ({score_p, ncards_p} !== '0) begin errors++; $display("FAIL to_hand: got score %0d ncards %0d required 0 0", score_p, ncards_p); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_err: got %0b required 0", err); end
    do_req(1'b0, 4'd0, 1'b1, lat, e, gets);
    checks++; if (lat !== 4 || e !== 1'b1) begin errors++; $display("FAIL code0: got lat %0d err %0b required 4 1", lat, e); end
    do_req(1'b0, 4'd13, 1'b1, lat, e, gets);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL code13_err: got %0b required 1", e); end
    checks++; if (ncards_p !== 4'd0 || last_card !== 4'd0) begin errors++; $display("FAIL code_bad_hand: got ncards %0d last %0d required 0 0", ncards_p, last_card); end
    do_req(1'b0, 4'd2, 1'b1, lat, e, gets);
    checks++; if (e !== 1'b0 || ncards_p !== 4'd1 || score_p !== 5'd2) begin errors++; $display("FAIL recover: got err %0b ncards %0d score %0d required 0 1 2", e, ncards_p, score_p); end
  endtask

  task automatic test_bust_reject();
    int lat, gets; bit e;
    apply_reset();
    do_req(1'b0, 4'd10, 1'b1, lat, e, gets);
    do_req(1'b0, 4'd10, 1'b1, lat, e, gets);
    do_req(1'b0, 4'd5, 1'b1, lat, e, gets);
    checks++; if (score_p !== 5'd25) begin errors++; $display("FAIL bust_score: got %0d required 25", score_p); end
    checks++; if (bust_p !== 1'b1) begin errors++; $display("FAIL bust_flag: got %0b required 1", bust_p); end
    do_req(1'b0, 4'd4, 1'b1, lat, e, gets);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL rej_ack: got lat %0d err %0b required 1 1", lat, e); end
    checks++; if (gets !== 0) begin errors++; $display("FAIL rej_getcard: got %0d required 0", gets); end
    checks++; if (ncards_p !== 4'd3) begin errors++; $display("FAIL rej_ncards: got %0d required 3", ncards_p); end
  endtask

  task automatic test_card_limit();
    int lat, gets; bit e;
    apply_reset();
    for (int k = 0; k < 15; k++) do_req(1'b1, 4'd11, 1'b1, lat, e, gets);
    checks++; if (ncards_d !== 4'd15) begin errors++; $display("FAIL lim_ncards: got %0d required 15", ncards_d); end
    checks++; if (score_d !== 5'd15 || soft_d !== 1'b0) begin errors++; $display("FAIL lim_score: got %0d soft %0b required 15 0", score_d, soft_d); end
    do_req(1'b1, 4'd11, 1'b1, lat, e, gets);
    checks++; if (lat !== 1 || e !== 1'b1 || gets !== 0) begin errors++; $display("FAIL lim_rej: got lat %0d err %0b gets %0d required 1 1 0", lat, e, gets); end
  endtask

  task automatic test_new_round();
    int lat, gets; bit e;
    int acks = 0;
    int busies = 0;
    int got = -1;
    apply_reset();
    do_req(1'b0, 4'd10, 1'b1, lat, e, gets);
    @(negedge clk);
    deck_card = 4'd6; deck_card_rdy = 1'b0; req_d = 1'b1;
    repeat (2) @(negedge clk);
    new_round = 1'b1; req_d = 1'b0;
    @(negedge clk);
    new_round = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nr_busy: got %0b required 0", busy); end
    checks++; if ({score_p, ncards_p, last_card, soft_p, bust_p} !== '0) begin errors++; $display("FAIL nr_clear: got score %0d ncards %0d last %0d required 0", score_p, ncards_p, last_card); end
    deck_card_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack_p || ack_d) acks++;
      if (busy) busies++;
    end
    checks++; if (acks !== 0 || busies !== 0) begin errors++; $display("FAIL nr_late_card: got acks %0d busy %0d required 0 0", acks, busies); end
    checks++; if (ncards_d !== 4'd0) begin errors++; $display("FAIL nr_late_ncards: got %0d required 0", ncards_d); end
    deck_card_rdy = 1'b0; deck_card = 4'd3;
    req_p = 1'b1; new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nr_same_cycle_req: got busy %0b required 0", busy); end
    @(negedge clk);
    checks++; if (deck_get_card !== 1'b1) begin errors++; $display("FAIL nr_next_grant: got %0b required 1", deck_get_card); end
    deck_card_rdy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack_p) begin got = i; e = err; break; end
    end
    req_p = 1'b0;
    checks++; if (got !== 3 || e !== 1'b0 || score_p !== 5'd3) begin errors++; $display("FAIL nr_after: got lat %0d err %0b score %0d required 3 0 3", got, e, score_p); end
  endtask

  initial begin
    test_reset();
    test_player_deal();
    test_soft_aces();
    test_round_robin();
    test_errors();
    test_bust_reject();
    test_card_limit();
    test_new_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
